// File: rtl/seed_g_sched_if.sv
// seed_g_sched_if: bundles the two requester handshakes, the shared SS table
// port and the result handshake of the SEED G-function scheduler.
interface seed_g_sched_if;
  // Requester 0 (round function)
  logic        req0_valid;
  logic [31:0] req0_data;
  logic        req0_ready;
  // Requester 1 (key schedule)
  logic        req1_valid;
  logic [31:0] req1_data;
  logic        req1_ready;
  // Shared SS table, combinational read
  logic [1:0]  ss_sel;
  logic [7:0]  ss_adrs;
  logic [31:0] ss_data;
  // Result handshake
  logic        res_valid;
  logic        res_id;
  logic [31:0] res_data;
  logic        res_ready;
  // Status
  logic        busy;

  // Scheduler side.
  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, ss_data, res_ready,
    output req0_ready, req1_ready, ss_sel, ss_adrs, res_valid, res_id, res_data, busy
  );

  // Requesters, table and consumer side.
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, ss_data, res_ready,
    input  req0_ready, req1_ready, ss_sel, ss_adrs, res_valid, res_id, res_data, busy
  );
endinterface : seed_g_sched_if

// File: rtl/seed_g_sched.sv
// seed_g_sched: shares one SS table read port between the round function and
// the key schedule. Each accepted operand Y is folded into
// G(Y) = SS0(Y0)^SS1(Y1)^SS2(Y2)^SS3(Y3) with one table lookup per cycle,
// giving one result every 6 cycles (grant, 4 lookups, result).
module seed_g_sched (
  input  logic          clk,
  input  logic          rst_n,
  seed_g_sched_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOOK = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cnt;      // table / byte index of the current lookup
  logic [31:0] r_acc;      // running XOR of table words
  logic [31:0] r_op;       // captured operand, immune to later input changes
  logic        r_id;       // owner of the operation in flight
  logic        r_last;     // last granted requester (round-robin pointer)

  logic        w_idle;
  logic        w_look;
  logic        w_done;
  logic        w_grant_en;
  logic        w_grant_id;
  logic        w_look_end;
  logic [7:0]  w_byte;

  assign w_idle     = (r_state == S_IDLE);
  assign w_look     = (r_state == S_LOOK);
  assign w_done     = (r_state == S_DONE);
  assign w_look_end = w_look && (r_cnt == 2'd3);

  // Round-robin grant: only offered in IDLE, and never while reset is held so
  // a requester cannot see a phantom handshake during reset.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves it unassigned and no latch can be inferred.
    w_grant_en = 1'b0;
    w_grant_id = 1'b0;
    if (w_idle && rst_n) begin
      if (bus.req0_valid && bus.req1_valid) begin
        w_grant_en = 1'b1;
        w_grant_id = ~r_last;
      end else if (bus.req0_valid) begin
        w_grant_en = 1'b1;
        w_grant_id = 1'b0;
      end else if (bus.req1_valid) begin
        w_grant_en = 1'b1;
        w_grant_id = 1'b1;
      end
    end
  end

  assign bus.req0_ready = w_grant_en & ~w_grant_id;
  assign bus.req1_ready = w_grant_en &  w_grant_id;

  // Next-state logic: IDLE -> LOOK on grant, LOOK x4 -> DONE, DONE -> IDLE on accept.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_en)    w_state_nxt = S_LOOK;
      S_LOOK:  if (w_look_end)    w_state_nxt = S_DONE;
      S_DONE:  if (bus.res_ready) w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: flops are written with non-blocking assignments so every register
      // samples the values that existed before the clock edge.
      r_state <= w_state_nxt;
    end
  end

  // Operand byte for the current lookup: cnt=0 -> Y0 (bits 7:0) ... cnt=3 -> Y3.
  always_comb begin
    w_byte = r_op[7:0];
    case (r_cnt)
      2'd1:    w_byte = r_op[15:8];
      2'd2:    w_byte = r_op[23:16];
      2'd3:    w_byte = r_op[31:24];
      default: w_byte = r_op[7:0];
    endcase
  end

  // Datapath: capture on grant, then fold one table word per LOOK cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= 2'd0;
      r_acc  <= 32'd0;
      r_op   <= 32'd0;
      r_id   <= 1'b0;
      r_last <= 1'b1;
    end else if (w_grant_en) begin
      r_op   <= w_grant_id ? bus.req1_data : bus.req0_data;
      r_id   <= w_grant_id;
      r_last <= w_grant_id;
      r_acc  <= 32'd0;
      r_cnt  <= 2'd0;
    end else if (w_look) begin
      r_acc  <= r_acc ^ bus.ss_data;
      r_cnt  <= r_cnt + 2'd1;
    end
  end

  // Table port is parked at 0 whenever no lookup is in progress.
  assign bus.ss_sel    = w_look ? r_cnt  : 2'd0;
  assign bus.ss_adrs   = w_look ? w_byte : 8'd0;

  // Result is only presented in DONE; acc cannot change there, so it holds.
  assign bus.res_valid = w_done;
  assign bus.res_id    = r_id;
  assign bus.res_data  = w_done ? r_acc : 32'd0;
  assign bus.busy      = ~w_idle;

endmodule : seed_g_sched
